// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and the processor control unit:
// opcode values, instruction field positions and sequencer state encoding.
package program_sequencer_pkg;

  // Opcodes held in IR[8:6]
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MV   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction field positions
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;
  localparam int RX_HI  = 5;
  localparam int RX_LO  = 3;
  localparam int RY_HI  = 2;
  localparam int RY_LO  = 0;

  // Sequencer state encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_REQ_OP    = 4'd1;
  localparam logic [3:0] ST_CAP_OP    = 4'd2;
  localparam logic [3:0] ST_REQ_IMM   = 4'd3;
  localparam logic [3:0] ST_CAP_IMM   = 4'd4;
  localparam logic [3:0] ST_ISSUE_OP  = 4'd5;
  localparam logic [3:0] ST_ISSUE_IMM = 4'd6;
  localparam logic [3:0] ST_WAIT_DONE = 4'd7;
  localparam logic [3:0] ST_HALT      = 4'd8;

  // Extract the opcode field from a 9-bit instruction word
  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/program_sequencer.sv
// Instruction feed: fetches words from a synchronous ROM, issues each
// instruction (plus the MVI immediate) to the processor on din/run, waits for
// done, and stops on a HALT opcode or when the done watchdog expires.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int WORD_W  = 9,
  parameter int TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        instr_count
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] op_q, op_d;
  logic [WORD_W-1:0] imm_q, imm_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  // Next-state logic; run/din are derived from the next state so they are
  // registered and valid in the very cycle the FSM enters an issue state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    imm_d   = imm_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = ST_REQ_OP;
        end
      end
      ST_REQ_OP: state_d = ST_CAP_OP;
      ST_CAP_OP: begin
        op_d = rom_data;
        pc_d = pc_q + ADDR_W'(1);
        case (rom_data[OPC_HI:OPC_LO])
          OP_HALT: state_d = ST_HALT;
          OP_MVI:  state_d = ST_REQ_IMM;
          default: state_d = ST_ISSUE_OP;
        endcase
      end
      ST_REQ_IMM: state_d = ST_CAP_IMM;
      ST_CAP_IMM: begin
        imm_d   = rom_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_ISSUE_OP;
      end
      ST_ISSUE_OP: begin
        wd_d    = '0;
        state_d = (op_q[OPC_HI:OPC_LO] == OP_MVI) ? ST_ISSUE_IMM : ST_WAIT_DONE;
      end
      ST_ISSUE_IMM: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_REQ_OP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_d = (state_d == ST_ISSUE_OP) || (state_d == ST_ISSUE_IMM) ||
            (state_d == ST_WAIT_DONE);
    din_d = din_q;
    if (state_d == ST_ISSUE_OP) begin
      din_d = op_d;
    end else if (state_d == ST_ISSUE_IMM) begin
      din_d = imm_q;
    end
  end

  // State and output registers; reset drops run immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      din_q   <= din_d;
      run_q   <= run_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign rom_addr    = pc_q;
  assign din         = din_q;
  assign run         = run_q;
  assign error       = err_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: ROM array, small processor model that
// raises done on the last run cycle of each opcode, one task per scenario.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] rom_addr;
  logic [8:0] rom_data;
  logic [8:0] din;
  logic       run;
  logic       done;
  logic       busy;
  logic       halted;
  logic       error;
  logic [7:0] instr_count;

  int errors = 0;
  int checks = 0;

  program_sequencer #(.ADDR_W(5), .WORD_W(9), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .din(din), .run(run), .done(done), .busy(busy),
    .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // Synchronous program ROM
  logic [8:0] rom [0:31];
  always @(posedge clock) rom_data <= rom[rom_addr];

  // Processor model: done on the last of NOP 2 / MV 3 / MVI 3 / ADD,SUB 4 run cycles
  logic [3:0] run_cyc = 4'd0;
  logic [2:0] held_op = 3'd0;
  logic [2:0] cur_op;
  logic [3:0] need;
  logic       proc_en = 1'b1;
  logic       spurious = 1'b0;

  always @(posedge clock) begin
    if (run) run_cyc <= run_cyc + 4'd1;
    else     run_cyc <= 4'd0;
    if (run && run_cyc == 4'd0) held_op <= din[8:6];
  end

  always_comb begin
    cur_op = (run_cyc == 4'd0) ? din[8:6] : held_op;
    case (cur_op)
      OP_MV, OP_MVI:  need = 4'd3;
      OP_ADD, OP_SUB: need = 4'd4;
      default:        need = 4'd2;
    endcase
    done = spurious | (proc_en && run && (run_cyc == need - 4'd1));
  end

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; spurious = 1'b0; proc_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Returns at the negedge after the edge that samples start
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_until_halt(output int rc, output logic [8:0] d0,
                                output logic [8:0] d1, output bit timed_out);
    rc = 0; d0 = '0; d1 = '0; timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (run) begin
        rc++;
        if (rc == 1) d0 = din;
        if (rc == 2) d1 = din;
      end
      if (halted) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({run, busy, halted, error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got run/busy/halted/error=%b expected 0000", {run, busy, halted, error});
    end
    checks++;
    if (din !== 9'h000 || rom_addr !== 5'd0 || instr_count !== 8'd0) begin
      errors++; $display("FAIL reset_values: got din=%h addr=%0d cnt=%0d expected 0/0/0", din, rom_addr, instr_count);
    end
    reset = 1'b0;
    @(negedge clock);
    $display("reset: run=%b din=%h addr=%0d", run, din, rom_addr);
  endtask

  task automatic test_mvi;
    int rc; logic [8:0] d0, d1; bit to;
    fill_rom(9'h1C0); rom[0] = 9'h100; rom[1] = 9'h005; rom[2] = 9'h1C0;
    do_reset(); pulse_start();
    run_until_halt(rc, d0, d1, to);
    checks++;
    if (to) begin errors++; $display("FAIL mvi_timeout: got no halt expected halt"); end
    checks++;
    if (d0 !== 9'h100) begin errors++; $display("FAIL mvi_issue_op: got %h expected 100", d0); end
    checks++;
    if (d1 !== 9'h005) begin errors++; $display("FAIL mvi_issue_imm: got %h expected 005", d1); end
    checks++;
    if (rc !== 3) begin errors++; $display("FAIL mvi_run_cycles: got %0d expected 3", rc); end
    checks++;
    if (instr_count !== 8'd1 || halted !== 1'b1 || rom_addr !== 5'd3 || error !== 1'b0) begin
      errors++; $display("FAIL mvi_final: got cnt=%0d halted=%b pc=%0d err=%b expected 1/1/3/0", instr_count, halted, rom_addr, error);
    end
    $display("mvi: din0=%h din1=%h run_cycles=%0d cnt=%0d pc=%0d", d0, d1, rc, instr_count, rom_addr);
  endtask

  task automatic test_add;
    int cyc = 0, rc = 0, first_run = 0, done_at = 0;
    fill_rom(9'h1C0); rom[0] = 9'h081;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); cyc++;
      if (cyc == 1) start = 1'b0;
      if (run) begin
        rc++;
        if (first_run == 0) first_run = cyc;
        if (done) done_at = rc;
      end
      if (halted) break;
    end
    checks++;
    if (first_run !== 3) begin errors++; $display("FAIL add_issue_latency: got cycle %0d expected 3", first_run); end
    checks++;
    if (rc !== 4 || done_at !== 4) begin errors++; $display("FAIL add_run_cycles: got run=%0d done_at=%0d expected 4/4", rc, done_at); end
    checks++;
    if (instr_count !== 8'd1 || halted !== 1'b1) begin
      errors++; $display("FAIL add_final: got cnt=%0d halted=%b expected 1/1", instr_count, halted);
    end
    $display("add: first_run=%0d run_cycles=%0d done_at=%0d cnt=%0d", first_run, rc, done_at, instr_count);
  endtask

  task automatic test_back_to_back;
    logic [11:0] seq = '0;
    bit to = 1'b1;
    fill_rom(9'h1C0); rom[0] = 9'h000; rom[1] = 9'h040;
    do_reset();
    start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (cyc == 1) start = 1'b0;
      if (cyc <= 12) seq[cyc-1] = run;
      if (halted) begin to = 1'b0; break; end
    end
    checks++;
    if (seq !== 12'h1CC) begin errors++; $display("FAIL b2b_run_pattern: got %h expected 1cc", seq); end
    checks++;
    if (to || instr_count !== 8'd2) begin errors++; $display("FAIL b2b_final: got cnt=%0d timeout=%0d expected 2/0", instr_count, to); end
    $display("back_to_back: run_pattern=%h cnt=%0d", seq, instr_count);
  endtask

  task automatic test_watchdog;
    int rc; logic [8:0] d0, d1; bit to;
    fill_rom(9'h1C0); rom[0] = 9'h040;
    do_reset(); proc_en = 1'b0;
    pulse_start();
    run_until_halt(rc, d0, d1, to);
    checks++;
    if (to || rc !== 5) begin errors++; $display("FAIL wd_run_cycles: got %0d timeout=%0d expected 5/0", rc, to); end
    checks++;
    if (error !== 1'b1 || halted !== 1'b1 || run !== 1'b0 || instr_count !== 8'd0) begin
      errors++; $display("FAIL wd_halt: got err=%b halted=%b run=%b cnt=%0d expected 1/1/0/0", error, halted, run, instr_count);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || halted !== 1'b0 || busy !== 1'b1 || rom_addr !== 5'd0) begin
      errors++; $display("FAIL wd_restart: got err=%b halted=%b busy=%b pc=%0d expected 0/0/1/0", error, halted, busy, rom_addr);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (run !== 1'b1 || din !== 9'h040 || rom_addr !== 5'd1) begin
      errors++; $display("FAIL wd_refetch: got run=%b din=%h pc=%0d expected 1/040/1", run, din, rom_addr);
    end
    $display("watchdog: run_cycles=%0d restart din=%h", rc, din);
    proc_en = 1'b1;
  endtask

  task automatic test_nop_wrap;
    int k = 0;
    bit to = 1'b1;
    fill_rom(9'h000);
    do_reset(); pulse_start();
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        if (k == 31) begin
          checks++;
          if (rom_addr !== 5'd0) begin errors++; $display("FAIL wrap_pc: got %0d expected 0", rom_addr); end
        end
        if (k == 255) begin
          checks++;
          if (instr_count !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: got %0d expected 255", instr_count); end
        end
        if (k == 256) begin
          checks++;
          if (instr_count !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d expected 0", instr_count); end
          to = 1'b0;
          break;
        end
        k++;
      end
      @(negedge clock);
    end
    checks++;
    if (to || halted !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wrap_running: got timeout=%0d halted=%b busy=%b expected 0/0/1", to, halted, busy);
    end
    $display("nop_wrap: instructions=%0d cnt=%0d", k, instr_count);
  endtask

  task automatic test_reset_mid;
    int rc; logic [8:0] d0, d1; bit to; bit found = 1'b0;
    fill_rom(9'h1C0); rom[0] = 9'h100; rom[1] = 9'h005;
    do_reset(); pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (run && din == 9'h005) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach_imm: got no ISSUE_IMM expected din=005"); end
    reset = 1'b1;
    #1;
    checks++;
    if (run !== 1'b0 || din !== 9'h000 || rom_addr !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got run=%b din=%h pc=%0d busy=%b expected 0/000/0/0", run, din, rom_addr, busy);
    end
    @(negedge clock); reset = 1'b0; @(negedge clock);
    pulse_start();
    run_until_halt(rc, d0, d1, to);
    checks++;
    if (to || d0 !== 9'h100 || d1 !== 9'h005 || instr_count !== 8'd1) begin
      errors++; $display("FAIL rmid_rerun: got din0=%h din1=%h cnt=%0d to=%0d expected 100/005/1/0", d0, d1, instr_count, to);
    end
    $display("reset_mid: rerun din0=%h din1=%h cnt=%0d", d0, d1, instr_count);
  endtask

  task automatic test_ignored;
    int cyc = 0, rc = 0;
    fill_rom(9'h1C0); rom[0] = 9'h081;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) spurious = 1'b1;
      if (cyc == 3) begin
        spurious = 1'b0;
        checks++;
        if (run !== 1'b1 || instr_count !== 8'd0) begin
          errors++; $display("FAIL ign_spurious_done: got run=%b cnt=%0d expected 1/0", run, instr_count);
        end
      end
      if (cyc == 4) start = 1'b1;
      if (cyc == 5) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || run !== 1'b1 || rom_addr !== 5'd1) begin
          errors++; $display("FAIL ign_start_busy: got busy=%b run=%b pc=%0d expected 1/1/1", busy, run, rom_addr);
        end
      end
      if (run) rc++;
      if (halted) break;
    end
    checks++;
    if (rc !== 4 || instr_count !== 8'd1 || halted !== 1'b1) begin
      errors++; $display("FAIL ign_final: got run=%0d cnt=%0d halted=%b expected 4/1/1", rc, instr_count, halted);
    end
    $display("ignored: run_cycles=%0d cnt=%0d", rc, instr_count);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    fill_rom(9'h1C0);
    test_reset();
    test_mvi();
    test_add();
    test_back_to_back();
    test_watchdog();
    test_nop_wrap();
    test_reset_mid();
    test_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-feed block that drives the processor's `din`/`run` inputs and consumes its `done` output. It fetches 9-bit words from a synchronous program ROM and presents each instruction at step 0 of the control unit. For MVI it also supplies the immediate word at step 1. It waits for `done`, then advances to the next instruction, and stops on a HALT opcode or a watchdog timeout.

## Interface
- `ADDR_W`, 5, program ROM address width (32 words)
- `WORD_W`, 9, instruction/data word width (IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry)
- `TIMEOUT`, 4, maximum cycles spent in WAIT_DONE without `done` before error halt
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values
- `start`  in  1  pulse; begins execution at address 0 when in IDLE or HALT; ignored otherwise
- `rom_addr`  out  ADDR_W  ROM read address, equals `pc`
- `rom_data`  in  WORD_W  ROM read data, valid one cycle after `rom_addr` is sampled
- `din`  out  WORD_W  word presented to processor data input, registered
- `run`  out  1  processor run enable, registered
- `done`  in  1  processor instruction-complete pulse
- `busy`  out  1  high in every state except IDLE and HALT
- `halted`  out  1  high in HALT
- `error`  out  1  sticky watchdog error, cleared by `start` or reset
- `instr_count`  out  8  completed-instruction count, wraps 255→0

## Operation
- Reset values: `pc`=0, `rom_addr`=0, `din`=0, `run`=0, `busy`=0, `halted`=0, `error`=0, `instr_count`=0, state IDLE.
- States: IDLE, REQ_OP, CAP_OP, REQ_IMM, CAP_IMM, ISSUE_OP, ISSUE_IMM, WAIT_DONE, HALT.
- IDLE/HALT + `start`: `pc`←0, `error`←0, `halted`←0, go to REQ_OP.
- REQ_OP: ROM samples `pc`. Go to CAP_OP.
- CAP_OP: `op_word`←`rom_data`, `pc`←`pc`+1 (wraps mod 2^ADDR_W).
  - Opcode 3'b111 (HALT) goes to HALT; the word is never issued.
  - Opcode 3'b100 (MVI) goes to REQ_IMM.
  - All other opcodes go to ISSUE_OP.
- REQ_IMM goes to CAP_IMM. CAP_IMM: `imm_word`←`rom_data`, `pc`←`pc`+1, go to ISSUE_OP.
- ISSUE_OP: `run`=1, `din`=`op_word`; the processor latches IR this cycle.
  - Next state is ISSUE_IMM if MVI, otherwise WAIT_DONE.
- ISSUE_IMM: `run`=1, `din`=`imm_word`; the processor drives the bus from `din`. Next state is WAIT_DONE.
- WAIT_DONE: `run`=1, `din` holds.
  - `done`=1: `instr_count`+1, `run`←0, go to REQ_OP.
  - `TIMEOUT` cycles without `done`: `error`←1, `run`←0, go to HALT.
- `done` outside WAIT_DONE is ignored.
- `start` while `busy` is ignored.
- `run` and `din` are registered. There is no combinational path from `done` or `rom_data` to any output.

## Timing
- `start` sampled at edge 0 → REQ_OP cycle 1, CAP_OP cycle 2, ISSUE_OP cycle 3 (`run` high).
- Non-MVI instructions: two `run`-low cycles (REQ_OP, CAP_OP) between the `done` cycle and the next ISSUE_OP.
- MVI: four `run`-low cycles before issue (REQ_OP, CAP_OP, REQ_IMM, CAP_IMM).
- `run`-high cycles per instruction:
  - NOP: 2
  - MV: 3
  - MVI: 3
  - ADD/SUB: 4
  - In each case `done` is seen on the last cycle.
- Watchdog counter clears on entry to WAIT_DONE. The error halt occurs at the edge ending the `TIMEOUT`-th WAIT_DONE cycle.
- `pc` wrap from 31 to 0 is legal and continues execution. An MVI at address 31 takes its immediate from address 0.
- Reset asserted mid-instruction: `run` drops immediately (async) and all outputs take reset values. The processor's own reset is expected to accompany it.

## Structure
- Shared package/header: opcode constants (OP_NOP 3'b000, OP_MV 3'b001, OP_ADD 3'b010, OP_SUB 3'b011, OP_MVI 3'b100, OP_HALT 3'b111), shared with the control unit; instruction field positions; state encoding.
- Single module. The watchdog is an inline `$clog2(TIMEOUT+1)`-bit counter; no sub-module.

## Test plan
- ROM {0:9'h100, 1:9'h005, 2:9'h1C0}, `start` pulse, processor model → ISSUE_OP `din`=9'h100, ISSUE_IMM `din`=9'h005; after `done` goes to HALT, `halted`=1, `instr_count`=1, `pc`=3.
- ROM {0:9'h081 (ADD R0,R1), 1:9'h1C0} → `run` high exactly 4 cycles, `done` on 4th, `instr_count`=1, `halted`=1.
- Processor stub never asserts `done`, ROM {0:9'h040} → after 4 WAIT_DONE cycles `error`=1, `halted`=1, `run`=0; then `start` clears `error`, refetches address 0.
- ROM filled with 9'h000 (NOP) at all 32 addresses → `pc` wraps 31→0, no halt, `instr_count` wraps 255→0 after 256 instructions.
- Reset asserted during ISSUE_IMM of an MVI → `run`=0, `din`=0, `pc`=0 asynchronously; `start` after release re-executes from address 0.
- `start` pulsed during WAIT_DONE, and a spurious `done` during CAP_OP → no state change, `instr_count` unchanged.
